// File: rtl/debounce_pkg.sv
// Shared types and widths for the multi-channel debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {ZERO, MID01, ONE, MID10} db_state_t;

    localparam int CNT_W  = 4;
    localparam int HOLD_W = 8;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, debounce FSM, edge strobes and,
// when LONGPRESS_EN is defined, a long-press hold strobe.
import debounce_pkg::*;

module debounce_chan #(
    parameter int   STABLE_TICKS = 2,
    parameter int   LONG_TICKS   = 50,
    parameter logic ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sw_raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

    logic [1:0]       sync_pipe;
    logic             s;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             enter_one;
    logic             enter_zero;

    // Reset to the inactive raw level so s starts at 0 for either polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= {2{ACTIVE_LOW}};
        else        sync_pipe <= {sync_pipe[0], sw_raw};
    end

    assign s          = sync_pipe[1] ^ ACTIVE_LOW;
    assign last       = (cnt == LAST);
    assign enter_one  = (state == MID01) && s  && tick && last;
    assign enter_zero = (state == MID10) && !s && tick && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ZERO;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ZERO: if (s) begin
                    state <= MID01;
                    cnt   <= '0;
                end
                MID01: begin
                    if (!s)             state <= ZERO;
                    else if (enter_one) begin
                        state <= ONE;
                        db    <= 1'b1;
                        rise  <= 1'b1;
                    end else if (tick)  cnt <= cnt + 1'b1;
                end
                ONE: if (!s) begin
                    state <= MID10;
                    cnt   <= '0;
                end
                MID10: begin
                    if (s)               state <= ONE;
                    else if (enter_zero) begin
                        state <= ZERO;
                        db    <= 1'b0;
                        fall  <= 1'b1;
                    end else if (tick)   cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= ZERO;
                    db    <= 1'b0;
                end
            endcase
        end
    end

`ifdef LONGPRESS_EN
    logic [HOLD_W-1:0] hcnt;

    // Counter saturates at LONG_TICKS, giving one hold strobe per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            hold <= 1'b0;
        end else begin
            hold <= 1'b0;
            if (enter_zero || enter_one) begin
                hcnt <= '0;
            end else if (tick && db && hcnt < HOLD_W'(LONG_TICKS)) begin
                hcnt <= hcnt + 1'b1;
                if (hcnt == HOLD_W'(LONG_TICKS - 1)) hold <= 1'b1;
            end
        end
    end
`else
    logic [HOLD_W-1:0] unused_long;
    assign unused_long = HOLD_W'(LONG_TICKS);
    assign hold        = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// CH-channel button/switch debouncer sharing one tick prescaler.
// Optional long-press strobe on hold[] is enabled by defining LONGPRESS_EN.
import debounce_pkg::*;

module debounce_bank #(
    parameter int            CH           = 4,
    parameter int            PRESCALE     = 1_000_000,
    parameter int            STABLE_TICKS = 2,
    parameter logic [CH-1:0] ACTIVE_LOW   = {CH{1'b1}},
    parameter int            LONG_TICKS   = 50
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] sw_raw,
    output logic [CH-1:0] db,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          tick,
    output logic [CH-1:0] hold
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;

    assign tick = (pcnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW[gi])
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .sw_raw (sw_raw[gi]),
            .db     (db[gi]),
            .rise   (rise[gi]),
            .fall   (fall[gi]),
            .hold   (hold[gi])
        );
    end

endmodule
